// File: rtl/calc_envelope_level.sv
// calc_envelope_level: per-operator ADSR envelope state/level tracker.
// p0 reads the operator's stored state and requests a rate; p2 applies the
// returned shift to the stored level and writes it back; p3 registers the
// updated level/state for the attenuation path.
module calc_envelope_level #(
    parameter int NUM_OPERATORS   = 18,
    parameter int ENV_WIDTH       = 9,
    parameter int PIPELINE_DELAY  = 3,
    parameter int OP_NUM_WIDTH    = $clog2(NUM_OPERATORS),
    parameter int REG_ENV_WIDTH   = 4,
    parameter int ENV_SHIFT_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_clk_en,
    input  logic [OP_NUM_WIDTH-1:0]    op_num,
    input  logic                       key_on,
    input  logic [REG_ENV_WIDTH-1:0]   ar,
    input  logic [REG_ENV_WIDTH-1:0]   dr,
    input  logic [REG_ENV_WIDTH-1:0]   rr,
    input  logic [REG_ENV_WIDTH-1:0]   sl,
    input  logic                       egt,
    output logic [REG_ENV_WIDTH-1:0]   requested_rate_p0,
    input  logic [ENV_SHIFT_WIDTH-1:0] env_shift_p2,
    input  logic [REG_ENV_WIDTH-1:0]   rate_hi_p2,
    output logic [ENV_WIDTH-1:0]       env_level_p3,
    output logic [1:0]                 env_state_p3
);

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_DECAY   = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_t;

    // number of register stages between p0 and p2
    localparam int STAGES = PIPELINE_DELAY - 1;
    localparam int SL_W   = ENV_WIDTH - 4;
    localparam logic [ENV_WIDTH-1:0]    LEVEL_MAX = '1;
    localparam logic [OP_NUM_WIDTH:0]   NUM_OPS_W = (OP_NUM_WIDTH + 1)'(NUM_OPERATORS);
    localparam logic signed [31:0]      LEVEL_MAX_S = 32'sd1 <<< ENV_WIDTH;

    // per-slot storage
    env_state_t             slot_state [NUM_OPERATORS];
    logic [ENV_WIDTH-1:0]   slot_level [NUM_OPERATORS];
    logic                   slot_kon   [NUM_OPERATORS];

    // p0 read of the addressed slot
    env_state_t             rd_state;
    logic [ENV_WIDTH-1:0]   rd_level;
    logic                   rd_kon;

    // p1..p2 delay line
    logic                     p_en    [STAGES];
    logic [OP_NUM_WIDTH-1:0]  p_op    [STAGES];
    logic                     p_kon   [STAGES];
    logic [REG_ENV_WIDTH-1:0] p_sl    [STAGES];
    logic                     p_egt   [STAGES];
    env_state_t               p_state [STAGES];
    logic [ENV_WIDTH-1:0]     p_level [STAGES];
    logic                     p_kprev [STAGES];

    // p2 computation
    env_state_t             st2;
    logic [ENV_WIDTH-1:0]   lv2;
    logic                   kon2;
    logic                   kp2;
    logic [SL_W-1:0]        sl_eff;
    logic signed [31:0]     lvl_ext;
    logic signed [31:0]     att_inc;
    logic signed [31:0]     att_sum;
    logic signed [31:0]     dec_sum;
    logic [ENV_WIDTH-1:0]   att_level;
    logic [ENV_WIDTH-1:0]   dec_level;
    env_state_t             nx_state;
    logic [ENV_WIDTH-1:0]   nx_level;
    logic                   upd;
    env_state_t             out_state;
    logic [ENV_WIDTH-1:0]   out_level;

    // p0: fetch the slot and pick the rate for the stored state
    always_comb begin
        rd_state          = ST_RELEASE;
        rd_level          = LEVEL_MAX;
        rd_kon            = 1'b0;
        requested_rate_p0 = rr;
        if ({1'b0, op_num} < NUM_OPS_W) begin
            rd_state = slot_state[op_num];
            rd_level = slot_level[op_num];
            rd_kon   = slot_kon[op_num];
        end
        case (rd_state)
            ST_ATTACK:  requested_rate_p0 = ar;
            ST_DECAY:   requested_rate_p0 = dr;
            ST_SUSTAIN: requested_rate_p0 = egt ? '0 : rr;
            default:    requested_rate_p0 = rr;
        endcase
    end

    // p0 -> p2 delay line, aligning slot data with the returned shift
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                p_en[i]    <= 1'b0;
                p_op[i]    <= '0;
                p_kon[i]   <= 1'b0;
                p_sl[i]    <= '0;
                p_egt[i]   <= 1'b0;
                p_state[i] <= ST_RELEASE;
                p_level[i] <= LEVEL_MAX;
                p_kprev[i] <= 1'b0;
            end
        end else begin
            p_en[0]    <= sample_clk_en;
            p_op[0]    <= op_num;
            p_kon[0]   <= key_on;
            p_sl[0]    <= sl;
            p_egt[0]   <= egt;
            p_state[0] <= rd_state;
            p_level[0] <= rd_level;
            p_kprev[0] <= rd_kon;
            for (int unsigned i = 1; i < STAGES; i++) begin
                p_en[i]    <= p_en[i-1];
                p_op[i]    <= p_op[i-1];
                p_kon[i]   <= p_kon[i-1];
                p_sl[i]    <= p_sl[i-1];
                p_egt[i]   <= p_egt[i-1];
                p_state[i] <= p_state[i-1];
                p_level[i] <= p_level[i-1];
                p_kprev[i] <= p_kprev[i-1];
            end
        end
    end

    // p2: level arithmetic for the attack curve and the linear steps
    always_comb begin
        st2    = p_state[STAGES-1];
        lv2    = p_level[STAGES-1];
        kon2   = p_kon[STAGES-1];
        kp2    = p_kprev[STAGES-1];
        sl_eff = (p_sl[STAGES-1] == '1) ? '1 : SL_W'(p_sl[STAGES-1]);
        // 32-bit signed keeps (~level <<< shift) exact for every shift value
        lvl_ext   = signed'({{(32-ENV_WIDTH){1'b0}}, lv2});
        att_inc   = (~lvl_ext <<< env_shift_p2) >>> 4;
        att_sum   = lvl_ext + att_inc;
        dec_sum   = lvl_ext + (32'sd1 <<< (env_shift_p2 - 1'b1));
        att_level = (att_sum < 0) ? '0 : att_sum[ENV_WIDTH-1:0];
        dec_level = (dec_sum >= LEVEL_MAX_S) ? LEVEL_MAX : dec_sum[ENV_WIDTH-1:0];
    end

    // p2: next state/level in priority order, gated by the slot update
    always_comb begin
        nx_state = st2;
        nx_level = lv2;
        if (kon2 && !kp2) begin
            nx_state = ST_ATTACK;
            if (rate_hi_p2 == '1) nx_level = '0;
        end else if (!kon2 && kp2) begin
            nx_state = ST_RELEASE;
            if (env_shift_p2 != '0) nx_level = dec_level;
        end else begin
            case (st2)
                ST_ATTACK: begin
                    if (lv2 == '0)
                        nx_state = ST_DECAY;
                    else if (rate_hi_p2 == '1)
                        nx_level = '0;
                    else if (env_shift_p2 != '0)
                        nx_level = att_level;
                end
                ST_DECAY: begin
                    if (lv2[ENV_WIDTH-1:4] == sl_eff)
                        nx_state = ST_SUSTAIN;
                    else if (env_shift_p2 != '0)
                        nx_level = dec_level;
                end
                default: begin
                    if (env_shift_p2 != '0) nx_level = dec_level;
                end
            endcase
        end
        upd       = p_en[STAGES-1] && ({1'b0, p_op[STAGES-1]} < NUM_OPS_W);
        out_state = upd ? nx_state : st2;
        out_level = upd ? nx_level : lv2;
    end

    // end of p2: slot write-back and p3 output register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_OPERATORS; i++) begin
                slot_state[i] <= ST_RELEASE;
                slot_level[i] <= LEVEL_MAX;
                slot_kon[i]   <= 1'b0;
            end
            env_level_p3 <= LEVEL_MAX;
            env_state_p3 <= ST_RELEASE;
        end else begin
            if (upd) begin
                slot_state[p_op[STAGES-1]] <= nx_state;
                slot_level[p_op[STAGES-1]] <= nx_level;
                slot_kon[p_op[STAGES-1]]   <= kon2;
            end
            env_level_p3 <= out_level;
            env_state_p3 <= out_state;
        end
    end

    // p_egt only matters at p0 (rate select); it is carried for alignment
    logic unused_egt;
    assign unused_egt = p_egt[STAGES-1];

endmodule

// File: tb/tb_calc_envelope_level.sv
// Testbench for calc_envelope_level: drives a 3-deep pipeline of operator
// transactions and checks rate requests and p3 levels against an envelope model.
module tb_calc_envelope_level;

    localparam int NOPS = 18;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_clk_en = 1'b0;
    logic [4:0] op_num = '0;
    logic       key_on = 1'b0;
    logic [3:0] ar = '0, dr = '0, rr = '0, sl = '0;
    logic       egt = 1'b0;
    logic [3:0] requested_rate_p0;
    logic [3:0] env_shift_p2 = '0;
    logic [3:0] rate_hi_p2 = '0;
    logic [8:0] env_level_p3;
    logic [1:0] env_state_p3;

    calc_envelope_level #(
        .NUM_OPERATORS(18),
        .ENV_WIDTH(9),
        .PIPELINE_DELAY(3),
        .OP_NUM_WIDTH(5),
        .REG_ENV_WIDTH(4),
        .ENV_SHIFT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_clk_en(sample_clk_en),
        .op_num(op_num),
        .key_on(key_on),
        .ar(ar),
        .dr(dr),
        .rr(rr),
        .sl(sl),
        .egt(egt),
        .requested_rate_p0(requested_rate_p0),
        .env_shift_p2(env_shift_p2),
        .rate_hi_p2(rate_hi_p2),
        .env_level_p3(env_level_p3),
        .env_state_p3(env_state_p3)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int op;
        bit kon;
        int ar, dr, rr, sl;
        bit egt;
        int shift;
        int rhi;
        bit en;
        int exp_level;
        int exp_state;
    } txn_t;

    // reference model: 0=ATTACK 1=DECAY 2=SUSTAIN 3=RELEASE
    int   m_state [NOPS];
    int   m_level [NOPS];
    bit   m_kprev [NOPS];

    txn_t pipe0, pipe1;
    int   tests_run = 0;
    int   tests_failed = 0;
    bit   obs_valid;
    int   obs_level, obs_state, obs_rate;

    function automatic txn_t mk(int op, bit kon, int a, int d, int r, int s, bit e,
                                int shift, int rhi, bit en);
        txn_t t;
        t.valid = 1'b1; t.op = op; t.kon = kon;
        t.ar = a; t.dr = d; t.rr = r; t.sl = s; t.egt = e;
        t.shift = shift; t.rhi = rhi; t.en = en;
        t.exp_level = 0; t.exp_state = 0;
        return t;
    endfunction

    function automatic txn_t bubble();
        txn_t t;
        t = mk(0, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0);
        t.valid = 1'b0;
        return t;
    endfunction

    function automatic int model_rate(txn_t t);
        case (m_state[t.op])
            0: return t.ar;
            1: return t.dr;
            2: return t.egt ? 0 : t.rr;
            default: return t.rr;
        endcase
    endfunction

    function automatic int lin_step(int lv, int shift);
        int v;
        if (shift == 0) return lv;
        v = lv + (2 ** (shift - 1));
        return (v > 511) ? 511 : v;
    endfunction

    task automatic model_step(inout txn_t t);
        int st, lv, sl_eff, dec;
        bit kp;
        st = m_state[t.op]; lv = m_level[t.op]; kp = m_kprev[t.op];
        sl_eff = (t.sl == 15) ? 31 : t.sl;
        if (t.kon && !kp) begin
            st = 0;
            if (t.rhi == 15) lv = 0;
        end else if (!t.kon && kp) begin
            st = 3;
            lv = lin_step(lv, t.shift);
        end else if (st == 0) begin
            if (lv == 0) st = 1;
            else if (t.rhi == 15) lv = 0;
            else if (t.shift > 0) begin
                // floor(-(lv+1) * 2^shift / 16)
                dec = ((lv + 1) * (2 ** t.shift) + 15) / 16;
                lv = lv - dec;
                if (lv < 0) lv = 0;
            end
        end else if (st == 1 && (lv / 16) == sl_eff) begin
            st = 2;
        end else begin
            lv = lin_step(lv, t.shift);
        end
        if (t.en) begin
            m_state[t.op] = st; m_level[t.op] = lv; m_kprev[t.op] = t.kon;
        end
        t.exp_state = m_state[t.op];
        t.exp_level = m_level[t.op];
    endtask

    task automatic model_reset();
        for (int i = 0; i < NOPS; i++) begin
            m_state[i] = 3; m_level[i] = 511; m_kprev[i] = 1'b0;
        end
        pipe0 = bubble();
        pipe1 = bubble();
    endtask

    // one clock: issue t at p0, feed pipe1 at p2, check pipe1's p3 result
    task automatic tick(input txn_t t_in);
        txn_t t;
        int exp_rate;
        t = t_in;
        sample_clk_en = t.valid ? t.en : 1'b0;
        op_num = 5'(t.op); key_on = t.kon;
        ar = 4'(t.ar); dr = 4'(t.dr); rr = 4'(t.rr); sl = 4'(t.sl); egt = t.egt;
        env_shift_p2 = pipe1.valid ? 4'(pipe1.shift) : 4'd0;
        rate_hi_p2   = pipe1.valid ? 4'(pipe1.rhi) : 4'd0;
        #1;
        obs_rate = int'(requested_rate_p0);
        if (t.valid) begin
            exp_rate = model_rate(t);
            tests_run++;
            if (requested_rate_p0 !== 4'(exp_rate)) begin
                tests_failed++;
                $display("FAIL requested_rate op %0d: got %0d expected %0d",
                         t.op, requested_rate_p0, exp_rate);
            end
            model_step(t);
        end
        @(posedge clk); #1;
        obs_valid = pipe1.valid;
        if (pipe1.valid) begin
            obs_level = int'(env_level_p3);
            obs_state = int'(env_state_p3);
            tests_run++;
            if (env_level_p3 !== 9'(pipe1.exp_level) || env_state_p3 !== 2'(pipe1.exp_state)) begin
                tests_failed++;
                $display("FAIL p3 op %0d: got level %h state %0d expected level %h state %0d",
                         pipe1.op, env_level_p3, env_state_p3, pipe1.exp_level, pipe1.exp_state);
            end
        end
        pipe1 = pipe0;
        pipe0 = t;
    endtask

    task automatic flush();
        tick(bubble());
        tick(bubble());
    endtask

    task automatic const_check(string name, int got, int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        sample_clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        const_check("reset level", int'(env_level_p3), 'h1FF);
        const_check("reset state", int'(env_state_p3), 3);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_sweep_idle();
        for (int op = 0; op < NOPS; op++) begin
            tick(mk(op, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                    $urandom_range(0, 15), 1'b1));
            const_check("idle rate is rr", obs_rate, int'(rr));
            if (obs_valid) begin
                const_check("idle level", obs_level, 'h1FF);
                const_check("idle state", obs_state, 3);
            end
        end
        flush();
    endtask

    task automatic test_attack_instant();
        tick(mk(5, 1'b1, 15, 4, 6, 3, 1'b0, 0, 15, 1'b1));
        flush();
        const_check("instant attack level", obs_level, 0);
        const_check("instant attack state", obs_state, 0);
        tick(mk(5, 1'b1, 15, 4, 6, 3, 1'b0, 0, 15, 1'b1));
        flush();
        const_check("attack->decay state", obs_state, 1);
    endtask

    task automatic test_attack_steps();
        int n;
        tick(mk(3, 1'b1, 7, 4, 6, 2, 1'b0, 0, 0, 1'b1));
        flush();
        const_check("key-on keeps level", obs_level, 'h1FF);
        const_check("key-on state", obs_state, 0);
        n = 0;
        while (obs_state != 1 && n < 20) begin
            tick(mk(3, 1'b1, 7, 4, 6, 2, 1'b0, 3, 0, 1'b1));
            flush();
            n++;
        end
        const_check("attack reaches decay", obs_state, 1);
        const_check("attack ends at 0", obs_level, 0);
    endtask

    task automatic test_decay_sustain();
        int n;
        n = 0;
        while (obs_state != 2 && n < 40) begin
            tick(mk(3, 1'b1, 7, 4, 9, 2, 1'b0, 2, 0, 1'b1));
            flush();
            n++;
        end
        const_check("decay reaches sustain", obs_state, 2);
        const_check("sustain level", obs_level, 'h20);
        tick(mk(3, 1'b1, 7, 4, 9, 2, 1'b1, 0, 0, 1'b1));
        const_check("egt sustain rate", obs_rate, 0);
        flush();
        const_check("egt sustain held", obs_level, 'h20);
        tick(mk(3, 1'b1, 7, 4, 9, 2, 1'b0, 2, 9, 1'b1));
        const_check("sustain rate rr", obs_rate, 9);
        flush();
        const_check("sustain step", obs_level, 'h22);
    endtask

    task automatic test_release_saturate();
        tick(mk(7, 1'b1, 15, 0, 5, 0, 1'b0, 0, 15, 1'b1));
        flush();
        for (int s = 9; s >= 2; s--) begin
            tick(mk(7, 1'b0, 15, 0, 5, 0, 1'b0, s, 0, 1'b1));
            flush();
        end
        const_check("release ramp level", obs_level, 'h1FE);
        const_check("release state", obs_state, 3);
        tick(mk(7, 1'b0, 15, 0, 5, 0, 1'b0, 3, 0, 1'b0));
        flush();
        const_check("disabled slot unchanged", obs_level, 'h1FE);
        tick(mk(7, 1'b0, 15, 0, 5, 0, 1'b0, 3, 0, 1'b1));
        flush();
        const_check("release saturates", obs_level, 'h1FF);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 30; r++) begin
            for (int op = 0; op < NOPS; op++) begin
                tick(mk(op, 1'($urandom_range(0, 7) < 5), $urandom_range(0, 15), $urandom_range(0, 15),
                        $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7),
                        $urandom_range(0, 15), 1'($urandom_range(0, 9) != 0)));
            end
        end
        flush();
    endtask

    task automatic test_reset_mid();
        for (int op = 0; op < 9; op++)
            tick(mk(op, 1'b1, 15, 3, 3, 3, 1'b0, 2, 15, 1'b1));
        apply_reset();
        for (int op = 0; op < NOPS; op++) begin
            tick(mk(op, 1'b0, 1, 2, 3, 4, 1'b0, 0, 0, 1'b1));
            if (obs_valid) const_check("post-reset level", obs_level, 'h1FF);
        end
        flush();
        tick(mk(8, 1'b1, 2, 2, 3, 4, 1'b0, 0, 0, 1'b1));
        flush();
        const_check("post-reset key-on level", obs_level, 'h1FF);
        const_check("post-reset key-on state", obs_state, 0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sweep_idle();
        test_attack_instant();
        test_attack_steps();
        test_decay_sustain();
        test_release_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
